// File: rtl/hazard_unit_if.sv
// Pipeline-hazard bus between the controller/datapath (master) and the hazard unit (slave).
interface hazard_unit_if #(parameter int CNT_W = 32);
    logic [4:0]       rsD, rtD, rsE, rtE;
    logic [4:0]       writeregE, writeregM, writeregW;
    logic             regwriteE, regwriteM, regwriteW;
    logic             memtoregE, memtoregM, memwriteM;
    logic             branchD, bneD, jumpD, pcsrcD;
    logic             dmem_ack;
    logic             forwardAD, forwardBD;
    logic [1:0]       forwardAE, forwardBE;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles, load_use_cnt;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM,
               branchD, bneD, jumpD, pcsrcD, dmem_ack,
        input  forwardAD, forwardBD, forwardAE, forwardBE,
               stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               mem_err, stall_cycles, load_use_cnt
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM,
               branchD, bneD, jumpD, pcsrcD, dmem_ack,
        output forwardAD, forwardBD, forwardAE, forwardBE,
               stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               mem_err, stall_cycles, load_use_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit: forwarding selects, load-use/branch stalls and a data-memory wait FSM.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.

// One operand's bypass logic; instantiated once per source register (rs, rt).
module hazardFwdLane (
    input  logic [4:0] srcD,
    input  logic [4:0] srcE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteM,
    input  logic       regwriteW,
    output logic [1:0] fwdE,
    output logic       fwdD
);
    logic hitEM, hitEW;

    assign hitEM = (srcE != 5'd0) && (srcE == writeregM) && regwriteM;
    assign hitEW = (srcE != 5'd0) && (srcE == writeregW) && regwriteW;
    assign fwdE  = hitEM ? 2'b10 : (hitEW ? 2'b01 : 2'b00);
    assign fwdD  = (srcD != 5'd0) && (srcD == writeregM) && regwriteM;
endmodule

module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_unit_if.slave hu
);
    localparam int NUM_OPS = 2;
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} memState_t;

    memState_t state, stateNxt;
    logic [7:0] waitCnt, waitCntNxt;
    logic       memErr, memStall, timeout, accM;
    logic       lwStall, brStall, stallAny;

    logic [NUM_OPS-1:0][4:0] srcD, srcE;
    logic [NUM_OPS-1:0][1:0] fwdE;
    logic [NUM_OPS-1:0]      fwdD;

    assign srcD = {hu.rtD, hu.rsD};
    assign srcE = {hu.rtE, hu.rsE};

    generate
        for (genvar g = 0; g < NUM_OPS; g++) begin : gOp
            hazardFwdLane uLane (
                .srcD      (srcD[g]),
                .srcE      (srcE[g]),
                .writeregM (hu.writeregM),
                .writeregW (hu.writeregW),
                .regwriteM (hu.regwriteM),
                .regwriteW (hu.regwriteW),
                .fwdE      (fwdE[g]),
                .fwdD      (fwdD[g])
            );
        end
    endgenerate

    assign lwStall = hu.memtoregE && (hu.rtE != 5'd0) &&
                     ((hu.rsD == hu.rtE) || (hu.rtD == hu.rtE));

    assign brStall = (hu.branchD || hu.bneD) &&
        ((hu.regwriteE && (hu.writeregE != 5'd0) &&
          ((hu.writeregE == hu.rsD) || (hu.writeregE == hu.rtD))) ||
         (hu.memtoregM && (hu.writeregM != 5'd0) &&
          ((hu.writeregM == hu.rsD) || (hu.writeregM == hu.rtD))));

    assign accM = hu.memtoregM || hu.memwriteM;

    // Memory wait: stall is Mealy so an ack releases the pipe in the same cycle.
    always_comb begin
        stateNxt   = state;
        waitCntNxt = waitCnt;
        memStall   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (accM && !hu.dmem_ack) begin
                    stateNxt   = WAIT;
                    waitCntNxt = 8'd1;
                    memStall   = 1'b1;
                end
            end
            WAIT: begin
                if (hu.dmem_ack) begin
                    stateNxt   = IDLE;
                    waitCntNxt = 8'd0;
                end else if (waitCnt == TIMEOUT_LAST) begin
                    stateNxt   = ERR;
                    waitCntNxt = 8'd0;
                    timeout    = 1'b1;
                end else begin
                    waitCntNxt = waitCnt + 8'd1;
                    memStall   = 1'b1;
                end
            end
            // One quiet cycle so the timed-out instruction is not stalled again.
            ERR:     stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            waitCnt <= 8'd0;
            memErr  <= 1'b0;
        end else begin
            state   <= stateNxt;
            waitCnt <= waitCntNxt;
            if (timeout) memErr <= 1'b1;
        end
    end

    assign stallAny = lwStall || brStall || memStall;

    // Everything is quiet while reset is held, regardless of FSM state.
    assign hu.forwardAE = reset ? fwdE[0] : 2'b00;
    assign hu.forwardBE = reset ? fwdE[1] : 2'b00;
    assign hu.forwardAD = reset && fwdD[0];
    assign hu.forwardBD = reset && fwdD[1];
    assign hu.stallF    = reset && stallAny;
    assign hu.stallD    = reset && stallAny;
    assign hu.stallE    = reset && memStall;
    assign hu.stallM    = reset && memStall;
    assign hu.flushW    = reset && memStall;
    assign hu.flushE    = reset && (lwStall || brStall) && !memStall;
    assign hu.flushD    = reset && (hu.pcsrcD || hu.jumpD) && !stallAny;
    assign hu.mem_err   = memErr;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stallCycles, loadUseCnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stallCycles <= '0;
            loadUseCnt  <= '0;
        end else begin
            if (stallAny && !(&stallCycles))
                stallCycles <= stallCycles + CNT_ONE;
            if (lwStall && !memStall && !(&loadUseCnt))
                loadUseCnt <= loadUseCnt + CNT_ONE;
        end
    end

    assign hu.stall_cycles = stallCycles;
    assign hu.load_use_cnt = loadUseCnt;
`else
    assign hu.stall_cycles = '0;
    assign hu.load_use_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed + randomized checks of hazard_unit against a cycle-level reference model.
module tb_hazard_unit;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CNT_W)) hu ();

    hazard_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hu    (hu.slave)
    );

    int nCmp = 0;
    int nErr = 0;

    // model state: stall cycles already spent on the current access, cooldown after timeout
    int               waited   = 0;
    bit               cooldown = 0;
    bit               errM     = 0;
    logic [CNT_W-1:0] mStall   = '0;
    logic [CNT_W-1:0] mLu      = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwdRef(input logic [4:0] src);
        if (hit(src, hu.writeregM) && hu.regwriteM) return 2'b10;
        if (hit(src, hu.writeregW) && hu.regwriteW) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clrIn();
        {hu.rsD, hu.rtD, hu.rsE, hu.rtE} = '0;
        {hu.writeregE, hu.writeregM, hu.writeregW} = '0;
        {hu.regwriteE, hu.regwriteM, hu.regwriteW} = '0;
        {hu.memtoregE, hu.memtoregM, hu.memwriteM} = '0;
        {hu.branchD, hu.bneD, hu.jumpD, hu.pcsrcD} = '0;
        hu.dmem_ack = 1'b0;
    endtask

    // Called at posedge+1 with inputs applied; checks, then advances the model one clock.
    task automatic step();
        bit accM, ack, eMem, eTo, lw, br, stallD;
        logic [5:0] eFwd;
        logic [6:0] eSt, oSt;
        #2;
        accM = hu.memtoregM || hu.memwriteM;
        ack  = hu.dmem_ack;
        eMem = 0;
        eTo  = 0;
        if (!cooldown) begin
            if (waited == 0)                   eMem = accM && !ack;
            else if (ack)                      eMem = 0;
            else if (waited == MEM_TIMEOUT-1)  eTo  = 1;
            else                               eMem = 1;
        end
        lw = hu.memtoregE && (hu.rtE != 0) && (hu.rsD == hu.rtE || hu.rtD == hu.rtE);
        br = (hu.branchD || hu.bneD) &&
             ((hu.regwriteE && (hit(hu.writeregE, hu.rsD) || hit(hu.writeregE, hu.rtD))) ||
              (hu.memtoregM && (hit(hu.writeregM, hu.rsD) || hit(hu.writeregM, hu.rtD))));
        stallD = lw || br || eMem;
        eFwd = {fwdRef(hu.rsE), fwdRef(hu.rtE),
                hit(hu.rsD, hu.writeregM) && hu.regwriteM,
                hit(hu.rtD, hu.writeregM) && hu.regwriteM};
        eSt  = {stallD, stallD, eMem, eMem, (hu.pcsrcD || hu.jumpD) && !stallD,
                (lw || br) && !eMem, eMem};
        if (!reset) begin
            eFwd = '0;
            eSt  = '0;
        end
        oSt = {hu.stallF, hu.stallD, hu.stallE, hu.stallM, hu.flushD, hu.flushE, hu.flushW};
        chk("fwd", {hu.forwardAE, hu.forwardBE, hu.forwardAD, hu.forwardBD}, eFwd);
        chk("stallflush", oSt, eSt);
        chk("mem_err", hu.mem_err, errM);
        chk("stall_cycles", hu.stall_cycles, mStall);
        chk("load_use_cnt", hu.load_use_cnt, mLu);
        @(posedge clk);
        if (!reset) begin
            waited = 0; cooldown = 0; errM = 0; mStall = '0; mLu = '0;
        end else begin
            cooldown = eTo;
            waited   = eMem ? waited + 1 : 0;
            if (eTo) errM = 1;
`ifdef HAZARD_PERF_CNT_EN
            if (eSt[6] && !(&mStall)) mStall = mStall + 1;
            if (lw && !eMem && !(&mLu)) mLu = mLu + 1;
`endif
        end
        #1;
    endtask

    initial begin
        int ackPct;
        reset = 1'b0;
        clrIn();
        @(posedge clk); #1;

        // reset: hazards present but everything forced quiet
        hu.memtoregE = 1; hu.rtE = 2; hu.rsD = 2; hu.pcsrcD = 1;
        hu.rsE = 5; hu.writeregM = 5; hu.regwriteM = 1;
        #1;
        chk("rst_stallF", hu.stallF, 0);
        chk("rst_fwdAE", hu.forwardAE, 2'b00);
        chk("rst_flushD", hu.flushD, 0);
        step();
        chk("rst_mem_err", hu.mem_err, 0);
        chk("rst_cnt", hu.stall_cycles, 0);
        reset = 1'b1;
        clrIn();
        step();

        // load-use then M->E forward
        hu.memtoregE = 1; hu.rtE = 2; hu.writeregE = 2; hu.regwriteE = 1; hu.rsD = 2;
        #1;
        chk("lw_stallF", hu.stallF, 1);
        chk("lw_stallD", hu.stallD, 1);
        chk("lw_flushE", hu.flushE, 1);
        chk("lw_fwdAE", hu.forwardAE, 2'b00);
        step();
        clrIn();
        hu.rsE = 2; hu.writeregM = 2; hu.regwriteM = 1; hu.memtoregM = 1; hu.dmem_ack = 1;
        #1;
        chk("lw_fwdAE_M", hu.forwardAE, 2'b10);
        step();

        // M over W priority, W only, r0 never forwards
        clrIn();
        hu.rsE = 5; hu.writeregM = 5; hu.writeregW = 5; hu.regwriteM = 1; hu.regwriteW = 1;
        #1; chk("fwd_MW", hu.forwardAE, 2'b10); step();
        hu.regwriteM = 0;
        #1; chk("fwd_W", hu.forwardAE, 2'b01); step();
        hu.regwriteM = 1; hu.rsE = 0; hu.writeregM = 0; hu.writeregW = 0;
        #1; chk("fwd_r0", hu.forwardAE, 2'b00); step();

        // branch hazard in E, then resolved by forwarding from M
        clrIn();
        hu.branchD = 1; hu.rsD = 3; hu.regwriteE = 1; hu.writeregE = 3;
        #1; chk("br_stallD", hu.stallD, 1); chk("br_flushE", hu.flushE, 1); step();
        hu.regwriteE = 0; hu.writeregE = 0; hu.writeregM = 3; hu.regwriteM = 1;
        #1; chk("br_nostall", hu.stallD, 0); chk("br_fwdAD", hu.forwardAD, 1); step();

        // slow memory: three wait cycles then ack
        clrIn();
        hu.memtoregM = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_stall", {hu.stallF, hu.stallD, hu.stallE, hu.stallM, hu.flushW}, 5'h1f);
            chk("mw_flushE", hu.flushE, 0);
            step();
        end
        hu.dmem_ack = 1;
        #1; chk("mw_release", {hu.stallF, hu.stallE, hu.flushW}, 3'b000); step();
        hu.dmem_ack = 0;
        #1; chk("mw_idle_again", hu.stallE, 1); step();
        hu.dmem_ack = 1; step();
        clrIn(); step();

        // timeout: 15 stall cycles, forced release, sticky error
        hu.memtoregM = 1;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            #1; chk("to_stall", hu.stallE, 1); step();
        end
        #1; chk("to_release", hu.stallE, 0); step();
        hu.memtoregM = 0;
        #1; chk("to_err", hu.mem_err, 1); step();
        step(); step();
        #1; chk("to_err_held", hu.mem_err, 1);
        reset = 0; step();
        reset = 1;
        #1; chk("to_err_clr", hu.mem_err, 0); step();

        // branch-taken flush, suppressed by a load-use stall
        clrIn();
        hu.pcsrcD = 1;
        #1; chk("flushD", hu.flushD, 1); step();
        hu.memtoregE = 1; hu.rtE = 4; hu.rtD = 4;
        #1; chk("flushD_lw", hu.flushD, 0); step();

        // four load-use stalls after a fresh reset
        clrIn();
        reset = 0; step(); reset = 1;
        hu.memtoregE = 1; hu.rtE = 6; hu.rsD = 6;
        repeat (4) step();
        clrIn();
        #1;
`ifdef HAZARD_PERF_CNT_EN
        chk("lu_cnt4", hu.load_use_cnt, 4);
`else
        chk("lu_cnt_off", hu.load_use_cnt, 0);
`endif
        step();

        // random phase; ack rate varies per block to reach timeouts as well as short waits
        ackPct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) ackPct = ($urandom_range(0, 3) == 0) ? 2 : 50;
            reset        = ($urandom_range(0, 199) != 0);
            hu.rsD       = 5'($urandom_range(0, 3));
            hu.rtD       = 5'($urandom_range(0, 3));
            hu.rsE       = 5'($urandom_range(0, 3));
            hu.rtE       = 5'($urandom_range(0, 3));
            hu.writeregE = 5'($urandom_range(0, 3));
            hu.writeregM = 5'($urandom_range(0, 3));
            hu.writeregW = 5'($urandom_range(0, 3));
            hu.regwriteE = 1'($urandom_range(0, 1));
            hu.regwriteM = 1'($urandom_range(0, 1));
            hu.regwriteW = 1'($urandom_range(0, 1));
            hu.memtoregE = ($urandom_range(0, 3) == 0);
            hu.memtoregM = ($urandom_range(0, 2) == 0);
            hu.memwriteM = ($urandom_range(0, 3) == 0);
            hu.branchD   = ($urandom_range(0, 3) == 0);
            hu.bneD      = ($urandom_range(0, 5) == 0);
            hu.jumpD     = ($urandom_range(0, 7) == 0);
            hu.pcsrcD    = ($urandom_range(0, 4) == 0);
            hu.dmem_ack  = ($urandom_range(0, 99) < ackPct);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
